// File: rtl/core_fifo_arbiter.sv
// Round-robin write arbiter sharing one fifo_mem write port between N_REQ cores.
// A multi-word message locks the arbiter to its owner so the words stay
// contiguous downstream. Occupancy is tracked with a credit counter, because
// fifo_mem has no full flag.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req/last/din       per-core request, final-word flag and data word
//   ack                combinational one-hot grant (word taken at this edge)
//   fifo_wr/fifo_din   registered write strobe and data to fifo_mem
//   fifo_rd/fifo_ready consumer pop observation, used to return credits
//   locked/owner/used  burst status, last granted core, credits in use
module core_fifo_arbiter #(
    parameter int unsigned  N_REQ     = 4,
    parameter int unsigned  BIT_WIDTH = 8,
    parameter int unsigned  MEM_SIZE  = 256,
    localparam int unsigned IDW       = $clog2(N_REQ),
    localparam int unsigned CW        = $clog2(MEM_SIZE) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           last,
    input  logic [N_REQ*BIT_WIDTH-1:0] din,
    output logic [N_REQ-1:0]           ack,
    output logic                       fifo_wr,
    output logic [BIT_WIDTH-1:0]       fifo_din,
    input  logic                       fifo_rd,
    input  logic                       fifo_ready,
    output logic                       locked,
    output logic [IDW-1:0]             owner,
    output logic [CW-1:0]              used
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t               r_state;
    logic [IDW-1:0]       r_rr_ptr;
    logic [IDW-1:0]       r_owner;
    logic [CW-1:0]        r_used;
    logic                 r_fifo_wr;
    logic [BIT_WIDTH-1:0] r_fifo_din;
    logic                 r_locked;

    logic                 w_can_push;
    logic                 w_pop;
    logic                 w_grant;
    logic [IDW-1:0]       w_gnt_idx;
    logic                 w_gnt_last;
    logic [BIT_WIDTH-1:0] w_gnt_din;
    logic [N_REQ-1:0]     w_ack;

    // Wrap-around successor of a requester index.
    function automatic logic [IDW-1:0] f_next(input logic [IDW-1:0] idx);
        if (32'(idx) == N_REQ - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    assign w_can_push = (r_used < CW'(MEM_SIZE));
    // A pop against an empty credit count is ignored.
    assign w_pop      = fifo_rd && fifo_ready && (r_used != '0);

    // Grant selection: owner only while locked, else round-robin from r_rr_ptr.
    always_comb begin
        logic [IDW-1:0] v_idx;
        w_ack     = '0;
        w_grant   = 1'b0;
        w_gnt_idx = '0;
        v_idx     = '0;
        if (!rst && w_can_push) begin
            if (r_state == ST_LOCK) begin
                if (req[r_owner]) begin
                    w_grant   = 1'b1;
                    w_gnt_idx = r_owner;
                end
            end else begin
                for (int unsigned k = 0; k < N_REQ; k++) begin
                    v_idx = IDW'((32'(r_rr_ptr) + k) % N_REQ);
                    if (!w_grant && req[v_idx]) begin
                        w_grant   = 1'b1;
                        w_gnt_idx = v_idx;
                    end
                end
            end
        end
        if (w_grant) begin
            w_ack[w_gnt_idx] = 1'b1;
        end
    end

    // Data/last mux for the granted core.
    always_comb begin
        w_gnt_din  = '0;
        w_gnt_last = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_ack[i]) begin
                w_gnt_din  = din[i*BIT_WIDTH +: BIT_WIDTH];
                w_gnt_last = last[i];
            end
        end
    end

    // Arbiter state, credits and registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_used     <= '0;
            r_fifo_wr  <= 1'b0;
            r_fifo_din <= '0;
            r_locked   <= 1'b0;
        end else begin
            r_fifo_wr <= w_grant;
            if (w_grant) begin
                r_fifo_din <= w_gnt_din;
            end

            if (w_grant && !w_pop) begin
                r_used <= r_used + 1'b1;
            end else if (!w_grant && w_pop) begin
                r_used <= r_used - 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_gnt_idx;
                        if (w_gnt_last) begin
                            r_rr_ptr <= f_next(w_gnt_idx);
                        end else begin
                            r_state  <= ST_LOCK;
                            r_locked <= 1'b1;
                        end
                    end
                end
                ST_LOCK: begin
                    // Owner may pause indefinitely; only its final word releases the lock.
                    if (w_grant && w_gnt_last) begin
                        r_state  <= ST_IDLE;
                        r_locked <= 1'b0;
                        r_rr_ptr <= f_next(r_owner);
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign ack      = w_ack;
    assign fifo_wr  = r_fifo_wr;
    assign fifo_din = r_fifo_din;
    assign locked   = r_locked;
    assign owner    = r_owner;
    assign used     = r_used;

endmodule

// File: doc/core_fifo_arbiter.md
Name: core_fifo_arbiter

Overview:
- Shares one downstream fifo_mem write port between N_REQ cores of the multi-core J1 cache system.
- Arbitrates round-robin and supports locked multi-word bursts, so one core's message stays contiguous in the queue.
- Tracks downstream occupancy with an internal credit counter, because fifo_mem exposes no full flag.
- Drives fifo_mem wr/din from registers and observes its rd/is_ready to return credits.

Parameters:
N_REQ, 4, number of requesting cores (2..8)
BIT_WIDTH, 8, data word width; must match downstream fifo_mem
MEM_SIZE, 256, downstream fifo depth; credit limit
IDW, $clog2(N_REQ), localparam, requester index width
CW, $clog2(MEM_SIZE)+1, localparam, credit counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req  in  N_REQ  per-core write request; held until acked
last  in  N_REQ  per-core final-word flag, valid with req
din  in  N_REQ*BIT_WIDTH  per-core word; core i occupies bits [i*BIT_WIDTH +: BIT_WIDTH]
ack  out  N_REQ  combinational one-hot grant; word accepted at this clock edge
fifo_wr  out  1  registered write strobe to fifo_mem wr
fifo_din  out  BIT_WIDTH  registered write data to fifo_mem din
fifo_rd  in  1  consumer read strobe presented to fifo_mem rd
fifo_ready  in  1  fifo_mem is_ready
locked  out  1  burst in progress
owner  out  IDW  current/last granted requester
used  out  CW  credits consumed (entries committed, not yet popped)

Behaviour:
- Reset (async, active-high): state=IDLE, rr_ptr=0, used=0, fifo_wr=0, fifo_din=0, owner=0, locked=0. ack=0 while rst is high.
- can_push = (used < MEM_SIZE).
- Acceptance: word accepted at a clock edge iff ack[i]=1 in that cycle. The core changes din/last or drops req only after that edge.
- Latency: fifo_wr=1 and fifo_din=din[i] in the cycle after the accepting edge. Otherwise fifo_wr=0 and fifo_din holds its last value.
- IDLE state:
  - ack goes to the first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N_REQ, only if can_push.
  - On grant with last=1: stay IDLE, rr_ptr <= i+1 (mod N_REQ).
  - On grant with last=0: go to LOCK, owner <= i.
  - owner also updates on single-word grants.
- LOCK state:
  - Only owner is eligible. ack[owner] = req[owner] && can_push. All other requesters wait.
  - On a grant with last=1: go to IDLE, rr_ptr <= owner+1.
  - Owner deasserting req mid-burst: remain in LOCK indefinitely. No timeout.
- locked = (state==LOCK), registered.
- Credits:
  - pop = fifo_rd && fifo_ready.
  - used += 1 on grant only; -= 1 on pop only; unchanged on grant and pop together.
  - Pop with used==0 is ignored (saturates at 0).
  - used never exceeds MEM_SIZE. At used==MEM_SIZE with a same-cycle pop, no grant is issued that cycle; the freed credit is usable next cycle.
- At most one ack bit is high per cycle. ack is never high while can_push=0.
- Reset mid-burst: lock is abandoned immediately. The partially written message stays in the downstream fifo, and used clears.
  - Downstream fifo_mem must share the reset.

Test Plan:
- Single word: reset, req[2]=1, last[2]=1, din[2]=8'hA5 -> ack=4'b0100 in that cycle; next cycle fifo_wr=1, fifo_din=8'hA5; used=1; rr_ptr=3.
- Round-robin: req=4'b1111, all last=1, held for 8 cycles, no pops -> ack sequence 0001,0010,0100,1000,0001,... ; used=8.
- Burst lock: core1 sends 3 words (last on third) while core0 and core3 request -> three consecutive acks to core1 with locked=1, then core3 granted before core0.
- Owner stall: core1 drops req for 5 cycles mid-burst while core0 requests -> ack=0 for those 5 cycles, locked stays 1, core0 ungranted.
- Full: MEM_SIZE=4, continuous req, no pops -> exactly 4 acks, used=4, ack=0 afterward. One cycle with fifo_rd=1, fifo_ready=1 -> used=3, next cycle one ack, used=4.
- Simultaneous grant+pop at used=2 -> used stays 2. Reset asserted mid-burst -> locked=0, used=0, fifo_wr=0 asynchronously; first grant after release is to the lowest requesting index (rr_ptr=0).
